// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and the branch unit.
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // Opcodes that can redirect fetch; the branch unit decodes these.
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_e;

  // One fetched instruction together with its address.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_ent_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory port: req/gnt address phase, in-order rvalid data phase.
interface fetch_if #(parameter int XLEN = 32);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_buf.sv
// One-entry prefetch buffer holding a returned word while decode is stalled.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  fetch_ent_t din_i,
  output fetch_ent_t dout_o,
  output logic       full_o
);
  logic       full_q;
  fetch_ent_t data_q;

  // Flush wins over push; push and pop never coincide (push only when output is held).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end else if (push_i) begin
      full_q <= 1'b1;
      data_q <= din_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign dout_o = data_q;
endmodule

// File: rtl/fetch_unit.sv
// PC + instruction fetch with one-deep prefetch and branch redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall,
  fetch_if.master         imem,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            misalign
);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, fetch_addr_q, tgt;
  logic            instr_valid_q, misalign_q;
  logic [XLEN-1:0] instr_q, instr_pc_q;
  logic            consume, redirect, mis_redir, gnt_acc, rv_acc;
  logic            pend_push, pend_pop, pend_full;
  fetch_ent_t      pend_din, pend_dout;
  logic            unused_bit0;

  assign consume     = instr_valid_q & ~stall;
  assign redirect    = consume & br_taken;
  assign tgt         = {br_target[XLEN-1:1], 1'b0};
  assign unused_bit0 = br_target[0];
  assign mis_redir   = redirect & tgt[1];
  assign gnt_acc     = (state_q == REQ) & imem.gnt;
  assign rv_acc      = (state_q == WAIT) & imem.rvalid;
  // Returned word parks in the buffer only when the output reg is full and held.
  assign pend_push   = rv_acc & ~redirect & instr_valid_q & ~consume;
  assign pend_pop    = consume & ~redirect & pend_full;
  assign pend_din    = '{instr: imem.rdata, pc: fetch_addr_q};

  fetch_buf u_buf (
    .clk(clk), .rst(rst),
    .push_i(pend_push), .pop_i(pend_pop), .flush_i(redirect),
    .din_i(pend_din), .dout_o(pend_dout), .full_o(pend_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= REQ;
    else      state_q <= state_d;
  end

  // Next state: a redirect may leave a response in flight, which DROP absorbs.
  always_comb begin
    state_d = state_q;
    if (misalign_q || mis_redir) begin
      state_d = IDLE;
    end else if (redirect) begin
      case (state_q)
        REQ:       state_d = imem.gnt    ? DROP : REQ;
        WAIT, DROP: state_d = imem.rvalid ? REQ  : DROP;
        default:   state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE:    if (!pend_full || pend_pop) state_d = REQ;
        REQ:     if (imem.gnt)    state_d = WAIT;
        WAIT:    if (imem.rvalid) state_d = pend_push ? IDLE : REQ;
        DROP:    if (imem.rvalid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; request is suppressed while reset is held.
  always_comb begin
    imem.req  = rst & (state_q == REQ);
    imem.addr = pc_q;
  end

  // PC advances on grant; a redirect replaces it outright (wraps mod 2^XLEN).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      fetch_addr_q <= '0;
    end else if (redirect) begin
      pc_q <= tgt;
    end else if (gnt_acc) begin
      fetch_addr_q <= pc_q;
      pc_q         <= pc_q + STEP;
    end
  end

  // Output register: pending entry first, then rvalid bypass, else empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      if (mis_redir) misalign_q <= 1'b1;
      if (redirect) begin
        instr_valid_q <= 1'b0;
      end else if (consume || !instr_valid_q) begin
        if (pend_full) begin
          instr_valid_q <= 1'b1;
          instr_q       <= pend_dout.instr;
          instr_pc_q    <= pend_dout.pc;
        end else if (rv_acc) begin
          instr_valid_q <= 1'b1;
          instr_q       <= imem.rdata;
          instr_pc_q    <= fetch_addr_q;
        end else begin
          instr_valid_q <= 1'b0;
        end
      end
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: instance 0 uses a zero-wait memory from PC 0, instance 1 a slow
// memory (gnt after 3 waits, rvalid 4 cycles later) starting at 0xFFFF_FFFC.
// Memory returns ~addr as the instruction word.
module tb_fetch_unit;
  logic        clk, rst;
  logic        br_taken  [2];
  logic [31:0] br_target [2];
  logic        stall     [2];
  logic        instr_valid [2];
  logic [31:0] instr [2], instr_pc [2];
  logic        misalign [2];
  logic        req_w [2], gnt_w [2];
  logic [31:0] addr_w [2];

  int ncmp = 0;
  int nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fetch_if #(.XLEN(32)) bus ();
    fetch_unit #(.XLEN(32), .RESET_PC(g == 1 ? 32'hFFFF_FFFC : 32'h0)) u_dut (
      .clk(clk), .rst(rst), .br_taken(br_taken[g]), .br_target(br_target[g]),
      .stall(stall[g]), .imem(bus), .instr_valid(instr_valid[g]),
      .instr(instr[g]), .instr_pc(instr_pc[g]), .misalign(misalign[g])
    );

    int          wcnt, rcnt;
    logic        rpend;
    logic [31:0] raddr;
    assign bus.gnt    = bus.req && (wcnt >= (g == 1 ? 3 : 0));
    assign bus.rvalid = rpend && (rcnt == 0);
    assign bus.rdata  = bus.rvalid ? ~raddr : 32'h0;
    assign req_w[g]   = bus.req;
    assign gnt_w[g]   = bus.gnt;
    assign addr_w[g]  = bus.addr;

    // Memory model: count wait cycles, then return the word after a fixed latency.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        wcnt <= 0; rcnt <= 0; rpend <= 1'b0; raddr <= 32'h0;
      end else begin
        if (bus.gnt) wcnt <= 0;
        else if (bus.req) wcnt <= wcnt + 1;
        if (bus.gnt) begin
          rpend <= 1'b1; rcnt <= (g == 1 ? 4 : 1) - 1; raddr <= bus.addr;
        end else if (bus.rvalid) rpend <= 1'b0;
        else if (rpend) rcnt <= rcnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge with a valid instruction (bounded).
  task automatic next_instr(input int g, input logic [31:0] exp_pc, input string tag);
    int n = 0;
    @(negedge clk);
    while (!instr_valid[g] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'b0, instr_valid[g]}, 32'd1);
    chk({tag, "_pc"}, instr_pc[g], exp_pc);
    chk({tag, "_instr"}, instr[g], ~exp_pc);
  endtask

  initial begin
    int reqs;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      br_taken[i] = 1'b0; br_target[i] = 32'h0; stall[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, instr_valid[0]}, 32'd0);
    chk("rst_req",   {31'b0, req_w[0]}, 32'd0);
    chk("rst_mis",   {31'b0, misalign[0]}, 32'd0);
    chk("rst_pc",    instr_pc[0], 32'h0);
    chk("rst_instr", instr[0], 32'h0);

    // 1: sequential fetch, latency and order
    rst = 1'b1;
    #1;
    chk("c1_req",  {31'b0, req_w[0]}, 32'd1);
    chk("c1_addr", addr_w[0], 32'h0);
    @(negedge clk);
    chk("c2_valid", {31'b0, instr_valid[0]}, 32'd0);
    @(negedge clk);
    chk("c3_valid", {31'b0, instr_valid[0]}, 32'd1);
    chk("c3_pc",    instr_pc[0], 32'h0);
    chk("c3_addr",  addr_w[0], 32'h4);
    next_instr(0, 32'h4, "seq4");
    next_instr(0, 32'h8, "seq8");
    chk("seq8_addr", addr_w[0], 32'hC);

    // 2: stall 5 cycles holding 0x8; 0xC parks in the buffer, no requests
    stall[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_pc",  instr_pc[0], 32'h8);
      chk("stall_req", {31'b0, req_w[0]}, 32'd0);
    end
    stall[0] = 1'b0;
    @(negedge clk);
    chk("unstall_valid", {31'b0, instr_valid[0]}, 32'd1);
    chk("unstall_pc",    instr_pc[0], 32'hC);
    chk("unstall_req",   {31'b0, req_w[0]}, 32'd1);

    // 5: br_taken while stalled is ignored
    stall[0] = 1'b1; br_taken[0] = 1'b1; br_target[0] = 32'h80;
    repeat (3) begin
      @(negedge clk);
      chk("brstall_pc", instr_pc[0], 32'hC);
    end
    stall[0] = 1'b0; br_taken[0] = 1'b0;
    next_instr(0, 32'h10, "brstall_next");

    // 3: redirect at 0x10 while 0x14 is being fetched
    chk("redir_addr", addr_w[0], 32'h14);
    br_taken[0] = 1'b1; br_target[0] = 32'h40;
    @(negedge clk);
    br_taken[0] = 1'b0;
    chk("redir_valid", {31'b0, instr_valid[0]}, 32'd0);
    chk("redir_drop",  {31'b0, req_w[0]}, 32'd0);
    next_instr(0, 32'h40, "redir40");
    next_instr(0, 32'h44, "redir44");

    // 4: misaligned target locks out fetch
    br_taken[0] = 1'b1; br_target[0] = 32'h43;
    @(negedge clk);
    br_taken[0] = 1'b0;
    chk("mis_flag",  {31'b0, misalign[0]}, 32'd1);
    chk("mis_valid", {31'b0, instr_valid[0]}, 32'd0);
    reqs = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_w[0] || instr_valid[0]) reqs++;
    end
    chk("mis_quiet", reqs, 32'd0);

    // reset mid-operation
    rst = 1'b0;
    #1;
    chk("rst2_mis",   {31'b0, misalign[0]}, 32'd0);
    chk("rst2_req",   {31'b0, req_w[0]}, 32'd0);
    chk("rst2_valid", {31'b0, instr_valid[1]}, 32'd0);
    chk("rst2_pc1",   instr_pc[1], 32'h0);

    // 6: slow memory, wrap from 0xFFFF_FFFC
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("slow_req",  {31'b0, req_w[1]}, 32'd1);
      chk("slow_addr", addr_w[1], 32'hFFFF_FFFC);
      chk("slow_gnt",  {31'b0, gnt_w[1]}, 32'd0);
    end
    @(negedge clk);
    chk("slow_gnt4",  {31'b0, gnt_w[1]}, 32'd1);
    chk("slow_addr4", addr_w[1], 32'hFFFF_FFFC);
    next_instr(1, 32'hFFFF_FFFC, "wrap_first");
    chk("wrap_addr", addr_w[1], 32'h0);
    next_instr(1, 32'h0, "wrap_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
